gate_state_scanner: RTL and testbench



---
 rtl/gate_state_scanner.sv | 149 ++++++++++++++
 tb/tb_gate_state_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_state_scanner.sv
// 16-channel time-multiplexed gate engine: reads one 59-bit channel record per clock,
// merges host config and triggers, advances delay/gate countdown and writes it back.
//
// state     | meaning
// ST_SWEEP  | post-reset clearing pass, zero written to addr 0..15
// ST_RUN    | normal servicing, one channel per clock
module gate_state_scanner (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] trig,
    input  logic        cfg_req,
    input  logic [3:0]  cfg_ch,
    input  logic [15:0] cfg_delay,
    input  logic [15:0] cfg_width,
    output logic        cfg_ack,
    output logic [3:0]  ram_addr,
    output logic [58:0] ram_wdata,
    input  logic [58:0] ram_rdata,
    output logic [15:0] gate_out,
    output logic        init_done
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_DELAY = 2'd1,
        PH_ON    = 2'd2,
        PH_RSVD  = 2'd3
    } phase_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ch;
    logic [15:0] trig_d;
    logic [15:0] pending;
    logic [15:0] pending_nxt;
    logic [15:0] edge_v;
    logic [15:0] ch_sel;
    logic [15:0] gate_vec_nxt;
    logic        running;
    logic        cfg_hit;
    logic        svc_trig;
    phase_t      phase_cur;
    phase_t      phase_nxt;
    logic [23:0] count_cur;
    logic [23:0] count_nxt;
    logic [15:0] delay_m;
    logic [15:0] width_m;
    logic        gate_w;
    // The stored gate bit is recomputed each service, never read back.
    logic        unused_gate;

    assign unused_gate = ram_rdata[58];
    assign ram_addr    = ch;
    assign init_done   = (state == ST_RUN);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_SWEEP;
            ch       <= 4'd0;
            trig_d   <= 16'd0;
            pending  <= 16'd0;
            gate_out <= 16'd0;
            cfg_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch       <= ch + 4'd1;
            trig_d   <= trig;
            pending  <= pending_nxt;
            gate_out <= gate_vec_nxt;
            cfg_ack  <= cfg_hit;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_SWEEP && ch == 4'd15) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        running  = (state == ST_RUN);
        edge_v   = trig & ~trig_d;
        ch_sel   = 16'd1 << ch;
        cfg_hit  = running && cfg_req && (cfg_ch == ch);
        svc_trig = running && (pending[ch] || edge_v[ch]);

        // Edges during the sweep stay pending until the channel's first real visit.
        pending_nxt = pending | edge_v;
        if (running) begin
            pending_nxt = pending_nxt & ~ch_sel;
        end

        phase_cur = phase_t'(ram_rdata[57:56]);
        count_cur = ram_rdata[55:32];
        delay_m   = cfg_hit ? cfg_delay : ram_rdata[31:16];
        width_m   = cfg_hit ? cfg_width : ram_rdata[15:0];

        phase_nxt = PH_IDLE;
        count_nxt = 24'd0;
        gate_w    = 1'b0;
        if (svc_trig) begin
            if (delay_m != 16'd0) begin
                phase_nxt = PH_DELAY;
                count_nxt = {delay_m, 8'h00};
            end else begin
                phase_nxt = PH_ON;
                count_nxt = {width_m, 8'h00};
                gate_w    = 1'b1;
            end
        end else begin
            case (phase_cur)
                PH_DELAY: begin
                    if (count_cur == 24'd0) begin
                        phase_nxt = PH_ON;
                        count_nxt = {width_m, 8'h00};
                        gate_w    = 1'b1;
                    end else begin
                        phase_nxt = PH_DELAY;
                        count_nxt = count_cur - 24'd1;
                    end
                end
                PH_ON: begin
                    if (count_cur != 24'd0) begin
                        phase_nxt = PH_ON;
                        count_nxt = count_cur - 24'd1;
                        gate_w    = 1'b1;
                    end
                end
                default: begin
                    phase_nxt = PH_IDLE;
                end
            endcase
        end

        ram_wdata    = 59'd0;
        gate_vec_nxt = gate_out;
        if (running) begin
            ram_wdata        = {gate_w, phase_nxt, count_nxt, delay_m, width_m};
            gate_vec_nxt[ch] = gate_w;
        end
    end

endmodule

// File: tb/tb_gate_state_scanner.sv
// Scoreboard bench for gate_state_scanner: stimulus queues expected gate/ack/sweep events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_gate_state_scanner;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] trig = 16'd0;
    logic        cfg_req = 1'b0;
    logic [3:0]  cfg_ch = 4'd0;
    logic [15:0] cfg_delay = 16'd0;
    logic [15:0] cfg_width = 16'd0;
    logic        cfg_ack;
    logic [3:0]  ram_addr;
    logic [58:0] ram_wdata;
    logic [58:0] ram_rdata;
    logic [15:0] gate_out;
    logic        init_done;

    logic [58:0] mem [16];
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    int          gate_cyc_q[$];
    logic [15:0] gate_val_q[$];
    int          ack_q[$];
    int          init_q[$];
    int          sweep_q[$];
    logic [15:0] gm = 16'd0;
    logic [15:0] gate_prev = 16'd0;
    logic        init_prev = 1'b0;

    gate_state_scanner dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .trig      (trig),
        .cfg_req   (cfg_req),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_ack   (cfg_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .gate_out  (gate_out),
        .init_done (init_done)
    );

    always #5 CLK = ~CLK;

    assign ram_rdata = mem[ram_addr];
    always @(posedge CLK) mem[ram_addr] <= ram_wdata;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cyc %0d, gate_out %0h", name, cyc, gate_out);
    endtask

    always @(negedge CLK) begin
        int e;
        if (RESET_N) begin
            if (!init_done) begin
                if (sweep_q.size() == 0) unexpected("sweep_extra");
                else begin
                    e = sweep_q.pop_front();
                    chk("sweep_addr", 64'(ram_addr), 64'(e));
                    chk("sweep_wdata", 64'(ram_wdata), 64'd0);
                    chk("sweep_gate", 64'(gate_out), 64'd0);
                    chk("sweep_ack", 64'(cfg_ack), 64'd0);
                end
            end
            if (init_done && !init_prev) begin
                if (init_q.size() == 0) unexpected("init_done_extra");
                else chk("init_done_cyc", 64'(cyc), 64'(init_q.pop_front()));
            end
            if (gate_out !== gate_prev) begin
                if (gate_cyc_q.size() == 0) unexpected("gate_extra");
                else begin
                    chk("gate_cyc", 64'(cyc), 64'(gate_cyc_q.pop_front()));
                    chk("gate_val", 64'(gate_out), 64'(gate_val_q.pop_front()));
                end
            end
            if (cfg_ack) begin
                if (ack_q.size() == 0) unexpected("ack_extra");
                else chk("ack_cyc", 64'(cyc), 64'(ack_q.pop_front()));
            end
        end
        gate_prev = gate_out;
        init_prev = init_done;
    end

    function automatic int svc(input int n, input int c);
        int s;
        s = (n < 16) ? 16 : n;
        return s + ((c - (s % 16) + 16) % 16);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic push_gate(input int at, input int c, input logic v);
        gm[c] = v;
        gate_cyc_q.push_back(at);
        gate_val_q.push_back(gm);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 16; i++) sweep_q.push_back(i);
        init_q.push_back(16);
    endtask

    task automatic do_cfg(input int c, input int d, input int w);
        int s;
        cfg_req   = 1'b1;
        cfg_ch    = 4'(c);
        cfg_delay = 16'(d);
        cfg_width = 16'(w);
        s = svc(cyc, c);
        ack_q.push_back(s + 1);
        wait_cyc(s + 1);
        cfg_req = 1'b0;
    endtask

    task automatic do_trig(input int c, output int s);
        trig[c] = 1'b1;
        s = svc(cyc, c);
        @(negedge CLK);
        trig[c] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, rise, fall, n;
        logic [63:0] t;
        for (int i = 0; i < 16; i++) begin
            t = {$urandom(), $urandom()};
            mem[i] = t[58:0] | 59'h1;
        end
        RESET_N = 1'b1;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_gate", 64'(gate_out), 64'd0);
        chk("reset_init_done", 64'(init_done), 64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);
        chk("reset_wdata", 64'(ram_wdata), 64'd0);
        push_sweep();
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(negedge CLK);

        // trig[3] during the sweep, zeroed record: width 0 -> one service period high
        wait_cyc(2);
        do_trig(3, s);
        push_gate(s + 1, 3, 1'b1);
        push_gate(s + 17, 3, 1'b0);
        wait_cyc(40);

        do_cfg(5, 0, 1);
        do_trig(5, s);
        push_gate(s + 1, 5, 1'b1);
        push_gate(s + 1 + 16 * 257, 5, 1'b0);
        wait_cyc(s + 1 + 16 * 257 + 4);

        do_cfg(2, 2, 0);
        do_trig(2, s);
        rise = s + 1 + 16 * 513;
        push_gate(rise, 2, 1'b1);
        push_gate(rise + 16, 2, 1'b0);
        wait_cyc(rise + 20);

        do_cfg(7, 0, 1);
        do_trig(7, s);
        push_gate(s + 1, 7, 1'b1);
        wait_cyc(s + 1 + 2000);
        do_trig(7, s2);
        fall = s2 + 1 + 16 * 257;
        push_gate(fall, 7, 1'b0);
        wait_cyc(fall + 4);

        // cfg for ch 9 issued while ch 10 is serviced; trigger lands in the commit cycle
        n = cyc + 1;
        n = n + ((10 - (n % 16) + 16) % 16);
        wait_cyc(n);
        cfg_req   = 1'b1;
        cfg_ch    = 4'd9;
        cfg_delay = 16'd0;
        cfg_width = 16'd1;
        s = svc(n, 9);
        ack_q.push_back(s + 1);
        wait_cyc(s);
        trig[9] = 1'b1;
        push_gate(s + 1, 9, 1'b1);
        fall = s + 1 + 16 * 257;
        push_gate(fall, 9, 1'b0);
        wait_cyc(s + 1);
        cfg_req = 1'b0;
        trig[9] = 1'b0;
        wait_cyc(fall + 4);

        do_cfg(4, 0, 1);
        do_trig(4, s);
        push_gate(s + 1, 4, 1'b1);
        wait_cyc(s + 100);
        n = cyc + 1;
        n = n + ((8 - (n % 16) + 16) % 16);
        wait_cyc(n);
        trig[6] = 1'b1;
        @(negedge CLK);
        trig[6] = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk("midrun_reset_gate", 64'(gate_out), 64'd0);
        chk("midrun_reset_init", 64'(init_done), 64'd0);
        chk("midrun_reset_ack", 64'(cfg_ack), 64'd0);
        gm = 16'd0;
        repeat (3) @(negedge CLK);
        push_sweep();
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        wait_cyc(120);
        chk("ch4_record_idle", 64'(mem[4]), 64'd0);
        chk("ch6_record_idle", 64'(mem[6]), 64'd0);
        chk("final_gate", 64'(gate_out), 64'd0);

        chk("gate_q_drained", 64'(gate_cyc_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        chk("init_q_drained", 64'(init_q.size()), 64'd0);
        chk("sweep_q_drained", 64'(sweep_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
